// File: rtl/vga_pkg.sv
// Shared VGA constants: default 640x480@60 timing, line/frame total helpers
// and the packed {r,g,b} pixel type at the default colour depth.
package vga_pkg;

  localparam int DEF_H_ACTIVE   = 640;
  localparam int DEF_H_FP       = 16;
  localparam int DEF_H_SYNC     = 96;
  localparam int DEF_H_BP       = 48;
  localparam int DEF_V_ACTIVE   = 480;
  localparam int DEF_V_FP       = 10;
  localparam int DEF_V_SYNC     = 2;
  localparam int DEF_V_BP       = 33;
  localparam int DEF_CELL_SHIFT = 4;
  localparam int DEF_COLOR_W    = 4;

  typedef struct packed {
    logic [DEF_COLOR_W-1:0] r;
    logic [DEF_COLOR_W-1:0] g;
    logic [DEF_COLOR_W-1:0] b;
  } rgb_t;

  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-tick divider plus horizontal/vertical scan counters with the raw
// (unregistered) sync, active-area and frame-origin flags derived from them.
module vga_timing
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int HW       = $clog2(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP)),
  parameter int VW       = $clog2(v_total(V_ACTIVE, V_FP, V_SYNC, V_BP))
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          tick,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output logic          active,
  output logic          hs_raw,
  output logic          vs_raw,
  output logic          frame_first
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int DW      = $clog2(CLK_DIV);

  logic [DW-1:0] div_cnt;

  assign tick = (div_cnt == DW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) begin
        if (h_cnt == HW'(H_TOTAL - 1)) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == VW'(V_TOTAL - 1)) ? '0 : v_cnt + 1'b1;
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end
    end
  end

  // Compared as int so a sync window ending exactly at 2**HW cannot truncate.
  assign active      = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
  assign hs_raw      = !((int'(h_cnt) >= H_ACTIVE + H_FP) && (int'(h_cnt) < H_ACTIVE + H_FP + H_SYNC));
  assign vs_raw      = !((int'(v_cnt) >= V_ACTIVE + V_FP) && (int'(v_cnt) < V_ACTIVE + V_FP + V_SYNC));
  assign frame_first = (h_cnt == '0) && (v_cnt == '0);

endmodule

// File: rtl/vga_cell_scanout.sv
// Cell-based VGA scan-out: reads a 1-bit-per-cell RAM and drives registered pins.
// Optional blinking cursor cell when VGA_CURSOR_EN is defined.
module vga_cell_scanout
  import vga_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter int CELL_SHIFT = DEF_CELL_SHIFT,
  parameter int COLOR_W    = DEF_COLOR_W,
  parameter int ADDR_W     = 11
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [ADDR_W-1:0]    fb_addr,
  output logic                 fb_rd_en,
  input  logic                 fb_data,
  input  logic [3*COLOR_W-1:0] fg_rgb,
  input  logic [3*COLOR_W-1:0] bg_rgb,
  input  logic [5:0]           cursor_col,
  input  logic [4:0]           cursor_row,
  output logic [COLOR_W-1:0]   vga_r,
  output logic [COLOR_W-1:0]   vga_g,
  output logic [COLOR_W-1:0]   vga_b,
  output logic                 vga_hs,
  output logic                 vga_vs,
  output logic                 frame_start
);

  localparam int COLS = H_ACTIVE >> CELL_SHIFT;
  localparam int ROWS = V_ACTIVE >> CELL_SHIFT;
  localparam int HW   = $clog2(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
  localparam int VW   = $clog2(v_total(V_ACTIVE, V_FP, V_SYNC, V_BP));

  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } pix_t;

  if (CLK_DIV < 2) begin : g_chk_div
    $error("vga_cell_scanout: CLK_DIV must be at least 2");
  end
  if ((H_ACTIVE % (1 << CELL_SHIFT)) != 0 || (V_ACTIVE % (1 << CELL_SHIFT)) != 0) begin : g_chk_cell
    $error("vga_cell_scanout: active area must be a whole number of cells");
  end
  if (ROWS * COLS - 1 >= (1 << ADDR_W)) begin : g_chk_addr
    $error("vga_cell_scanout: ADDR_W too small for ROWS*COLS cells");
  end

  logic          tick, active, hs_raw, vs_raw, frame_first;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;

  vga_timing #(
    .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .HW(HW), .VW(VW)
  ) u_timing (
    .clk(clk), .rst_n(rst_n), .tick(tick), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .active(active), .hs_raw(hs_raw), .vs_raw(vs_raw), .frame_first(frame_first)
  );

  logic [ADDR_W-1:0]    cell_row, cell_col;
  logic [3*COLOR_W-1:0] fg_q, bg_q;
  logic                 s1_active, s1_hs, s1_vs, s1_first, s1_cursor;
  logic                 rd_pend, cell_q, cell_bit, cursor_hit, swap;
  pix_t                 pix;

  assign cell_row = ADDR_W'(v_cnt >> CELL_SHIFT);
  assign cell_col = ADDR_W'(h_cnt >> CELL_SHIFT);

`ifdef VGA_CURSOR_EN
  logic [5:0] cur_col_q;
  logic [4:0] cur_row_q;
  logic [4:0] frame_cnt;
  logic       blink_phase;
  logic [5:0] cur_col_sel;
  logic [4:0] cur_row_sel;

  // At the frame origin the freshly sampled cursor must already apply to pixel (0,0).
  assign cur_col_sel = frame_first ? cursor_col : cur_col_q;
  assign cur_row_sel = frame_first ? cursor_row : cur_row_q;
  assign cursor_hit  = active && (int'(h_cnt >> CELL_SHIFT) == int'(cur_col_sel))
                              && (int'(v_cnt >> CELL_SHIFT) == int'(cur_row_sel));
  assign swap        = s1_cursor && !blink_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_col_q   <= '0;
      cur_row_q   <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (tick && frame_first) begin
      cur_col_q   <= cursor_col;
      cur_row_q   <= cursor_row;
      blink_phase <= frame_cnt[4];
      frame_cnt   <= frame_cnt + 1'b1;
    end
  end
`else
  logic unused_cursor;
  assign unused_cursor = ^{cursor_col, cursor_row};
  assign cursor_hit    = 1'b0;
  assign swap          = 1'b0;
`endif

  // The RAM bit is only live the clk after the read; later ticks use the captured copy.
  assign cell_bit = rd_pend ? fb_data : cell_q;
  assign pix      = !s1_active ? '0 : ((cell_bit ^ swap) ? pix_t'(fg_q) : pix_t'(bg_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_addr     <= '0;
      fb_rd_en    <= 1'b0;
      rd_pend     <= 1'b0;
      cell_q      <= 1'b0;
      fg_q        <= '0;
      bg_q        <= '0;
      s1_active   <= 1'b0;
      s1_hs       <= 1'b1;
      s1_vs       <= 1'b1;
      s1_first    <= 1'b0;
      s1_cursor   <= 1'b0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      fb_rd_en    <= 1'b0;
      frame_start <= 1'b0;
      rd_pend     <= fb_rd_en;
      if (rd_pend) cell_q <= fb_data;
      if (tick) begin
        if (active) begin
          fb_addr  <= cell_row * ADDR_W'(COLS) + cell_col;
          fb_rd_en <= 1'b1;
        end
        if (frame_first) begin
          fg_q <= fg_rgb;
          bg_q <= bg_rgb;
        end
        s1_active   <= active;
        s1_hs       <= hs_raw;
        s1_vs       <= vs_raw;
        s1_first    <= frame_first;
        s1_cursor   <= cursor_hit;
        vga_r       <= pix.r;
        vga_g       <= pix.g;
        vga_b       <= pix.b;
        vga_hs      <= s1_hs;
        vga_vs      <= s1_vs;
        frame_start <= s1_first;
      end
    end
  end

endmodule
